// File: rtl/dds_cordic_mc.sv
// Multi-channel DDS: round-robin phase accumulators time-share one unrolled,
// pipelined CORDIC that emits channel-tagged quadrature samples.
module dds_cordic_mc #(
  parameter int unsigned PW   = 16,
  parameter int unsigned AW   = 16,
  parameter int unsigned NCH  = 4,
  parameter int unsigned ITER = 14,
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cen,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [CHW-1:0]       cfg_ch,
  input  logic [PW-1:0]        cfg_data,
  input  logic                 sync,
  output logic signed [AW-1:0] sin_out,
  output logic signed [AW-1:0] cos_out,
  output logic [CHW-1:0]       out_ch,
  output logic                 out_valid
);

  localparam int unsigned XW = AW + 2;
  localparam int unsigned ZW = PW + 2;
  localparam int AMAX_I = (2 ** (AW - 1)) - 1;
  localparam int X0_I   = $rtoi(0.6072529 * real'(AMAX_I) + 0.5);
  localparam logic signed [XW-1:0] X_INIT = XW'(X0_I);
  localparam logic signed [XW-1:0] AMAX   = XW'(AMAX_I);

  // atan(2^-i) in phase units (full turn = 2^PW), rounded, packed per stage
  function automatic logic [ITER*ZW-1:0] atan_tab();
    logic [ITER*ZW-1:0] tab;
    real t;
    real a;
    tab = '0;
    t   = 1.0;
    for (int i = 0; i < int'(ITER); i++) begin
      a = $atan(t) / (2.0 * 3.14159265358979) * (2.0 ** PW);
      tab[i*ZW +: ZW] = ZW'($rtoi(a + 0.5));
      t = t / 2.0;
    end
    return tab;
  endfunction

  localparam logic [ITER*ZW-1:0] ATAN_TAB = atan_tab();

  function automatic logic signed [AW-1:0] sat(input logic signed [XW-1:0] v);
    if (v > AMAX) return AW'(AMAX);
    if (v < -AMAX) return AW'(-AMAX);
    return AW'(v);
  endfunction

  logic [PW-1:0]  fcw    [NCH];
  logic [PW-1:0]  offset [NCH];
  logic [PW-1:0]  acc    [NCH];
  logic [CHW-1:0] ch_ptr;
  logic [PW-1:0]  phase_c;
  logic           inject_c;

  assign phase_c  = acc[ch_ptr] + offset[ch_ptr];
  assign inject_c = cen & ~sync;

  // Scheduler and per-channel config; serviced channel sees pre-write values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_ptr <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        fcw[i]    <= '0;
        offset[i] <= '0;
        acc[i]    <= '0;
      end
    end else begin
      if (sync) begin
        ch_ptr <= '0;
        for (int i = 0; i < int'(NCH); i++) acc[i] <= '0;
      end else if (cen) begin
        acc[ch_ptr] <= acc[ch_ptr] + fcw[ch_ptr];
        ch_ptr      <= (ch_ptr == CHW'(NCH - 1)) ? '0 : ch_ptr + CHW'(1);
      end
      if (cfg_we) begin
        for (int i = 0; i < int'(NCH); i++) begin
          if (cfg_ch == CHW'(i)) begin
            if (cfg_sel) offset[i] <= cfg_data;
            else         fcw[i]    <= cfg_data;
          end
        end
      end
    end
  end

  logic signed [XW-1:0] xp [ITER+1];
  logic signed [XW-1:0] yp [ITER+1];
  logic signed [ZW-1:0] zp [ITER+1];
  logic [1:0]           qp [ITER+1];
  logic [CHW-1:0]       cp [ITER+1];
  logic [ITER:0]        vp;

  // Fold register (index 0) then ITER micro-rotations. z0 is the raw residual
  // in [0, quarter turn); the 45-degree first stage supplies the centring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= int'(ITER); i++) begin
        xp[i] <= '0;
        yp[i] <= '0;
        zp[i] <= '0;
        qp[i] <= '0;
        cp[i] <= '0;
      end
      vp <= '0;
    end else begin
      xp[0] <= X_INIT;
      yp[0] <= '0;
      zp[0] <= ZW'(phase_c[PW-3:0]);
      qp[0] <= phase_c[PW-1 -: 2];
      cp[0] <= ch_ptr;
      vp[0] <= inject_c;
      for (int i = 0; i < int'(ITER); i++) begin
        if (zp[i][ZW-1]) begin
          xp[i+1] <= xp[i] + (yp[i] >>> i);
          yp[i+1] <= yp[i] - (xp[i] >>> i);
          zp[i+1] <= zp[i] + $signed(ATAN_TAB[i*ZW +: ZW]);
        end else begin
          xp[i+1] <= xp[i] - (yp[i] >>> i);
          yp[i+1] <= yp[i] + (xp[i] >>> i);
          zp[i+1] <= zp[i] - $signed(ATAN_TAB[i*ZW +: ZW]);
        end
        qp[i+1] <= qp[i];
        cp[i+1] <= cp[i];
        vp[i+1] <= vp[i];
      end
    end
  end

  logic signed [XW-1:0] map_cos_c;
  logic signed [XW-1:0] map_sin_c;

  // Quadrant restore
  always_comb begin
    map_cos_c = xp[ITER];
    map_sin_c = yp[ITER];
    case (qp[ITER])
      2'd1: begin
        map_cos_c = -yp[ITER];
        map_sin_c = xp[ITER];
      end
      2'd2: begin
        map_cos_c = -xp[ITER];
        map_sin_c = -yp[ITER];
      end
      2'd3: begin
        map_cos_c = yp[ITER];
        map_sin_c = -xp[ITER];
      end
      default: begin
        map_cos_c = xp[ITER];
        map_sin_c = yp[ITER];
      end
    endcase
  end

  // Output register: samples hold while no new one arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sin_out   <= '0;
      cos_out   <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vp[ITER];
      if (vp[ITER]) begin
        cos_out <= sat(map_cos_c);
        sin_out <= sat(map_sin_c);
        out_ch  <= cp[ITER];
      end
    end
  end

endmodule

// File: tb/tb_dds_cordic_mc.sv
// Directed bench for dds_cordic_mc: a scheduler scoreboard predicts every output
// cycle; sample values come from hand-derived sin/cos constants.
module tb_dds_cordic_mc;

  localparam int unsigned PW   = 16;
  localparam int unsigned AW   = 16;
  localparam int unsigned NCH  = 4;
  localparam int unsigned ITER = 14;
  localparam int unsigned CHW  = 2;
  localparam int unsigned LAT  = ITER + 2;

  logic                 clk;
  logic                 reset;
  logic                 cen;
  logic                 cfg_we;
  logic                 cfg_sel;
  logic [CHW-1:0]       cfg_ch;
  logic [PW-1:0]        cfg_data;
  logic                 sync;
  logic signed [AW-1:0] sin_out;
  logic signed [AW-1:0] cos_out;
  logic [CHW-1:0]       out_ch;
  logic                 out_valid;

  logic                 cfg3_we;
  logic                 cfg3_sel;
  logic [1:0]           cfg3_ch;
  logic [PW-1:0]        cfg3_data;
  logic signed [AW-1:0] sin3;
  logic signed [AW-1:0] cos3;
  logic [1:0]           ch3;
  logic                 v3;

  typedef struct {
    bit            v;
    int            ch;
    logic [PW-1:0] ph;
  } ent_t;

  ent_t          pq[$];
  logic [PW-1:0] m_fcw [NCH];
  logic [PW-1:0] m_off [NCH];
  logic [PW-1:0] m_acc [NCH];
  int            m_ptr;
  int            ch3_exp;
  int            n3;
  bit            seen_valid;
  int            checks;
  int            errors;

  dds_cordic_mc #(.PW(PW), .AW(AW), .NCH(NCH), .ITER(ITER)) u_dut (
    .clk(clk), .reset(reset), .cen(cen), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_ch(cfg_ch), .cfg_data(cfg_data), .sync(sync), .sin_out(sin_out),
    .cos_out(cos_out), .out_ch(out_ch), .out_valid(out_valid)
  );

  // Three-channel instance: non-power-of-two wrap and out-of-range config writes
  dds_cordic_mc #(.PW(PW), .AW(AW), .NCH(3), .ITER(ITER)) u_dut3 (
    .clk(clk), .reset(reset), .cen(1'b1), .cfg_we(cfg3_we), .cfg_sel(cfg3_sel),
    .cfg_ch(cfg3_ch), .cfg_data(cfg3_data), .sync(1'b0), .sin_out(sin3),
    .cos_out(cos3), .out_ch(ch3), .out_valid(v3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  function automatic bit near(input logic signed [AW-1:0] a, input int e);
    int d;
    d = int'(a) - e;
    return (d <= 3) && (d >= -3);
  endfunction

  function automatic void exp_cs(input logic [PW-1:0] ph, output int c, output int s);
    case (ph)
      16'h0000: begin c = 32767;  s = 0;      end
      16'h2000: begin c = 23170;  s = 23170;  end
      16'h4000: begin c = 0;      s = 32767;  end
      16'h8000: begin c = -32767; s = 0;      end
      16'hC000: begin c = 0;      s = -32767; end
      default:  begin c = 99999;  s = 99999;  end
    endcase
  endfunction

  task automatic model_clear();
    ent_t z;
    z.v = 1'b0; z.ch = 0; z.ph = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      m_fcw[i] = '0; m_off[i] = '0; m_acc[i] = '0;
    end
    m_ptr = 0; ch3_exp = 0; seen_valid = 1'b0;
    pq.delete();
    for (int i = 0; i < int'(LAT) - 1; i++) pq.push_back(z);
  endtask

  task automatic compare(input ent_t e);
    int ec, es;
    checks++;
    assert (out_valid === e.v) else begin
      errors++; $error("FAIL out_valid got=%b exp=%b t=%0t", out_valid, e.v, $time);
    end
    if (e.v) begin
      exp_cs(e.ph, ec, es);
      seen_valid = 1'b1;
      checks++;
      assert (out_ch === CHW'(e.ch)) else begin
        errors++; $error("FAIL out_ch got=%0d exp=%0d t=%0t", out_ch, e.ch, $time);
      end
      checks++;
      assert (near(cos_out, ec) === 1'b1) else begin
        errors++; $error("FAIL cos ch%0d ph=%h got=%0d exp=%0d t=%0t", e.ch, e.ph, cos_out, ec, $time);
      end
      checks++;
      assert (near(sin_out, es) === 1'b1) else begin
        errors++; $error("FAIL sin ch%0d ph=%h got=%0d exp=%0d t=%0t", e.ch, e.ph, sin_out, es, $time);
      end
    end else if (!seen_valid) begin
      checks++;
      assert ({cos_out, sin_out, out_ch} === '0) else begin
        errors++; $error("FAIL idle_zero got cos=%0d sin=%0d ch=%0d exp=0 t=%0t", cos_out, sin_out, out_ch, $time);
      end
    end
  endtask

  task automatic check3();
    if (v3) begin
      checks++;
      assert (ch3 === 2'(ch3_exp)) else begin
        errors++; $error("FAIL nch3_ch got=%0d exp=%0d t=%0t", ch3, ch3_exp, $time);
      end
      checks++;
      assert ((near(cos3, 32767) && near(sin3, 0)) === 1'b1) else begin
        errors++; $error("FAIL nch3_val got=(%0d,%0d) exp=(32767,0) t=%0t", cos3, sin3, $time);
      end
      ch3_exp = (ch3_exp + 1) % 3;
      n3++;
    end
  endtask

  task automatic check_reset_outs(input string tag);
    checks++;
    assert ({out_valid, cos_out, sin_out, out_ch} === '0) else begin
      errors++; $error("FAIL %s got v=%b cos=%0d sin=%0d ch=%0d exp=all0", tag, out_valid, cos_out, sin_out, out_ch);
    end
    checks++;
    assert (v3 === 1'b0) else begin
      errors++; $error("FAIL %s_nch3 got v=%b exp=0", tag, v3);
    end
  endtask

  // One clock: predict what this edge injects, then score the output
  task automatic tick();
    ent_t e;
    e.v = 1'b0; e.ch = 0; e.ph = '0;
    if (!reset) begin
      if (sync) begin
        for (int i = 0; i < int'(NCH); i++) m_acc[i] = '0;
        m_ptr = 0;
      end else if (cen) begin
        e.v = 1'b1; e.ch = m_ptr; e.ph = m_acc[m_ptr] + m_off[m_ptr];
        m_acc[m_ptr] = m_acc[m_ptr] + m_fcw[m_ptr];
        m_ptr = (m_ptr + 1) % int'(NCH);
      end
      if (cfg_we && (int'(cfg_ch) < int'(NCH))) begin
        if (cfg_sel) m_off[cfg_ch] = cfg_data;
        else         m_fcw[cfg_ch] = cfg_data;
      end
    end
    @(posedge clk);
    #1;
    if (reset) model_clear();
    else pq.push_back(e);
    if (pq.size() >= int'(LAT)) compare(pq.pop_front());
    check3();
  endtask

  task automatic cfg_write(input logic sel, input logic [CHW-1:0] ch, input logic [PW-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; n3 = 0;
    reset = 1'b1; cen = 1'b0; sync = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_ch = '0; cfg_data = '0;
    cfg3_we = 1'b0; cfg3_sel = 1'b0; cfg3_ch = '0; cfg3_data = '0;
    model_clear();
    tick();
    tick();
    check_reset_outs("reset_state");
    reset = 1'b0;
    tick();

    // Channel setup; the 3-channel instance gets writes aimed at channel 3
    cfg3_we = 1'b1; cfg3_sel = 1'b0; cfg3_ch = 2'd3; cfg3_data = 16'h4000;
    cfg_write(1'b0, 2'd0, 16'h4000);
    cfg3_sel = 1'b1;
    cfg_write(1'b0, 2'd1, 16'h8000);
    cfg3_we = 1'b0;
    cfg_write(1'b1, 2'd2, 16'h2000);

    // Continuous run: latency, round-robin order, quadrant walk, wrap
    cen = 1'b1;
    repeat (LAT + 24) tick();

    // Three-cycle stall
    cen = 1'b0;
    repeat (3) tick();
    cen = 1'b1;
    repeat (LAT + 8) tick();

    // Re-phase with a concurrent offset write to channel 0
    sync = 1'b1;
    cfg_write(1'b1, 2'd0, 16'h4000);
    sync = 1'b0;
    repeat (LAT + 8) tick();

    // Config write to the channel being serviced this very cycle
    for (int k = 0; (k < int'(NCH)) && (m_ptr != 3); k++) tick();
    cfg_write(1'b0, 2'd3, 16'h4000);
    repeat (LAT + 12) tick();

    // Asynchronous reset between edges
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outs("async_reset");
    tick();
    check_reset_outs("reset_hold");
    reset = 1'b0;
    repeat (LAT + 8) tick();

    checks++;
    assert (n3 >= 20) else begin
      errors++; $error("FAIL nch3_count got=%0d exp>=20", n3);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
